// File: rtl/sequencer.sv
// Two-state accumulator sequencer: FETCH latches an instruction, EXEC runs it.
// Instruction word is {opcode, operand}; the operand is a data address or branch target.
module sequencer #(
    parameter int unsigned WORD_W = 8,
    parameter int unsigned OP_W   = 3
) (
    input  logic                     clock,
    input  logic                     n_reset,
    input  logic                     stall,
    output logic [WORD_W-OP_W-1:0]   Iaddress,
    input  logic [WORD_W-1:0]        Idata,
    output logic [WORD_W-OP_W-1:0]   Daddress,
    input  logic [WORD_W-1:0]        Ddata_rd,
    output logic [WORD_W-1:0]        Ddata_wr,
    output logic                     Dwe,
    output logic [WORD_W-1:0]        acc,
    output logic                     zero
);

    localparam int unsigned A_W = WORD_W - OP_W;

    localparam logic [OP_W-1:0] OpNop   = OP_W'(0);
    localparam logic [OP_W-1:0] OpLoad  = OP_W'(1);
    localparam logic [OP_W-1:0] OpStore = OP_W'(2);
    localparam logic [OP_W-1:0] OpAdd   = OP_W'(3);
    localparam logic [OP_W-1:0] OpSub   = OP_W'(4);
    localparam logic [OP_W-1:0] OpBne   = OP_W'(5);

    typedef enum logic {StFetch, StExec} state_e;

    state_e              state_q, state_d;
    logic [A_W-1:0]      pc_q, pc_d;
    logic [WORD_W-1:0]   ir_q, ir_d;
    logic [WORD_W-1:0]   acc_q, acc_d;
    logic                z_q, z_d;

    logic [OP_W-1:0]     opcode;
    logic [A_W-1:0]      operand;
    logic [WORD_W-1:0]   alu_res;

    assign opcode  = ir_q[WORD_W-1:A_W];
    assign operand = ir_q[A_W-1:0];

    // State register; reset clears everything asynchronously so Dwe drops at once
    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            state_q <= StFetch;
            pc_q    <= '0;
            ir_q    <= '0;
            acc_q   <= '0;
            z_q     <= 1'b1;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            acc_q   <= acc_d;
            z_q     <= z_d;
        end
    end

    // Next-state: fetch unless stalled, then execute the latched instruction
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        acc_d   = acc_q;
        z_d     = z_q;
        alu_res = '0;
        unique case (state_q)
            StFetch: begin
                if (!stall) begin
                    ir_d    = Idata;
                    pc_d    = pc_q + 1'b1;
                    state_d = StExec;
                end
            end
            StExec: begin
                state_d = StFetch;
                case (opcode)
                    OpLoad: acc_d = Ddata_rd;
                    OpAdd: begin
                        alu_res = acc_q + Ddata_rd;
                        acc_d   = alu_res;
                        z_d     = (alu_res == '0);
                    end
                    OpSub: begin
                        alu_res = acc_q - Ddata_rd;
                        acc_d   = alu_res;
                        z_d     = (alu_res == '0);
                    end
                    OpBne: begin
                        if (!z_q) begin
                            pc_d = operand;
                        end
                    end
                    // STORE acts only through Dwe; NOP and undefined opcodes do nothing
                    OpStore, OpNop: ;
                    default: ;
                endcase
            end
            default: state_d = StFetch;
        endcase
    end

    // Memory-facing outputs are pure decodes of the registered state
    always_comb begin
        Iaddress = pc_q;
        Daddress = (state_q == StExec) ? operand : '0;
        Dwe      = (state_q == StExec) && (opcode == OpStore);
        Ddata_wr = acc_q;
        acc      = acc_q;
        zero     = z_q;
    end

endmodule

// File: tb/tb_sequencer.sv
// Bench for sequencer: behavioural instruction/data memories, a queue of expected data
// writes drained by a write monitor, and directed checks of PC/ACC/Z around each scenario.
module tb_sequencer;

    localparam int unsigned WORD_W = 8;
    localparam int unsigned OP_W   = 3;
    localparam int unsigned A_W    = WORD_W - OP_W;

    logic              clock;
    logic              n_reset;
    logic              stall;
    logic [A_W-1:0]    Iaddress;
    logic [WORD_W-1:0] Idata;
    logic [A_W-1:0]    Daddress;
    logic [WORD_W-1:0] Ddata_rd;
    logic [WORD_W-1:0] Ddata_wr;
    logic              Dwe;
    logic [WORD_W-1:0] acc;
    logic              zero;

    logic [WORD_W-1:0] imem [32];
    logic [WORD_W-1:0] dmem [32];

    logic [12:0] exp_q [$];   // {addr, data} of each expected store

    int n_checks = 0;
    int n_fail   = 0;

    sequencer #(.WORD_W(WORD_W), .OP_W(OP_W)) dut (
        .clock    (clock),
        .n_reset  (n_reset),
        .stall    (stall),
        .Iaddress (Iaddress),
        .Idata    (Idata),
        .Daddress (Daddress),
        .Ddata_rd (Ddata_rd),
        .Ddata_wr (Ddata_wr),
        .Dwe      (Dwe),
        .acc      (acc),
        .zero     (zero)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    assign Idata    = imem[Iaddress];
    assign Ddata_rd = dmem[Daddress];

    always @(posedge clock) begin
        if (Dwe) dmem[Daddress] <= Ddata_wr;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Write monitor: every store the DUT presents must match the head of the queue
    always @(negedge clock) begin
        if (n_reset && Dwe) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_store: got addr %0d data 0x%0h, expected none",
                         Daddress, Ddata_wr);
            end else begin
                check("store", {19'd0, Daddress, Ddata_wr}, {19'd0, exp_q.pop_front()});
            end
        end
    end

    function automatic logic [7:0] ins(input logic [2:0] op, input logic [4:0] a);
        return {op, a};
    endfunction

    task automatic step(input int n);
        for (int i = 0; i < n; i++) @(negedge clock);
    endtask

    initial begin
        bit found;

        for (int i = 0; i < 32; i++) begin
            imem[i] = 8'h00;
            dmem[i] = 8'h00;
        end
        // Accumulating loop: mem[30] += mem[31] until the 8-bit sum wraps to zero
        imem[0] = ins(3'b010, 5'd30);  // STORE 30
        imem[1] = ins(3'b001, 5'd30);  // LOAD 30
        imem[2] = ins(3'b011, 5'd31);  // ADD 31
        imem[3] = ins(3'b010, 5'd30);  // STORE 30
        imem[4] = ins(3'b101, 5'd1);   // BNE 1
        imem[5] = ins(3'b001, 5'd7);   // LOAD 7
        imem[6] = ins(3'b100, 5'd7);   // SUB 7
        imem[7] = ins(3'b101, 5'd0);   // BNE 0 (not taken, Z=1)
        imem[8] = ins(3'b110, 5'd0);   // undefined -> NOP
        imem[9] = ins(3'b111, 5'd31);  // undefined -> NOP
        dmem[0]  = 8'h5A;
        dmem[7]  = 8'h05;
        dmem[31] = 8'h02;

        exp_q.push_back({5'd30, 8'd0});
        for (int k = 1; k < 128; k++) exp_q.push_back({5'd30, 8'(2 * k)});
        exp_q.push_back({5'd30, 8'd0});

        // Reset values
        stall   = 1'b1;
        n_reset = 1'b0;
        #12;
        check("rst_iaddr", 32'(Iaddress), 32'd0);
        check("rst_acc", 32'(acc), 32'd0);
        check("rst_zero", 32'(zero), 32'd1);
        check("rst_dwe", 32'(Dwe), 32'd0);

        // Stall holds everything for 5 cycles
        @(negedge clock);
        n_reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check("stall_iaddr", 32'(Iaddress), 32'd0);
            check("stall_acc_zero", {23'd0, acc, zero}, {23'd0, 8'd0, 1'b1});
            check("stall_dwe", 32'(Dwe), 32'd0);
        end
        stall = 1'b0;
        @(negedge clock);
        check("first_fetch", 32'(Iaddress), 32'd1);

        // Loop runs 128 iterations; wait for its final store to drain
        found = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clock);
            if (exp_q.size() == 0 && Iaddress == 5'd5) begin
                found = 1'b1;
                break;
            end
        end
        check("loop_done", 32'(found), 32'd1);
        step(1);
        check("bne_fallthrough", 32'(Iaddress), 32'd5);
        check("loop_acc", 32'(acc), 32'd0);
        check("loop_zero", 32'(zero), 32'd1);

        // LOAD 7 then SUB 7 -> zero result sets Z
        step(2);
        check("load_acc", 32'(acc), 32'h05);
        step(2);
        check("sub_acc", 32'(acc), 32'h00);
        check("sub_zero", 32'(zero), 32'd1);
        step(2);
        check("bne_not_taken", 32'(Iaddress), 32'd8);

        // Undefined opcodes behave as NOP
        step(1);
        check("undef6_dwe", 32'(Dwe), 32'd0);
        step(1);
        check("undef6_state", {15'd0, Iaddress, acc, zero}, {15'd0, 5'd9, 8'd0, 1'b1});
        step(1);
        check("undef7_dwe", 32'(Dwe), 32'd0);
        step(1);
        check("undef7_state", {15'd0, Iaddress, acc, zero}, {15'd0, 5'd10, 8'd0, 1'b1});
        check("undef_dmem", {dmem[0], dmem[31]}, {8'h5A, 8'h02});

        // NOPs through to 31, then PC wraps to 0
        found = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clock);
            if (Iaddress == 5'd31) begin
                found = 1'b1;
                break;
            end
        end
        check("reach_31", 32'(found), 32'd1);
        imem[0] = ins(3'b001, 5'd0);   // LOAD 0
        imem[1] = ins(3'b010, 5'd29);  // STORE 29 (to be aborted by reset)
        step(1);
        check("pc_31", 32'(Iaddress), 32'd31);
        step(1);
        check("pc_wrap", 32'(Iaddress), 32'd0);
        step(3);
        check("reload_acc", 32'(acc), 32'h5A);

        // Abort a STORE mid-EXEC with asynchronous reset
        @(posedge clock);
        #2;
        check("store_dwe_pre", 32'(Dwe), 32'd1);
        check("store_data_pre", {19'd0, Daddress, Ddata_wr}, {19'd0, 5'd29, 8'h5A});
        n_reset = 1'b0;
        #1;
        check("async_dwe", 32'(Dwe), 32'd0);
        check("async_acc", 32'(acc), 32'd0);
        check("async_zero", 32'(zero), 32'd1);
        check("async_iaddr", 32'(Iaddress), 32'd0);
        step(2);
        check("aborted_store", 32'(dmem[29]), 32'd0);
        n_reset = 1'b1;
        @(negedge clock);
        check("post_reset_fetch", 32'(Iaddress), 32'd1);
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
